// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter: fixed-priority fetch/debug arbiter for the instruction-memory read port with starvation escape; optional IM_ARB_FAULT_EN address checking
module im_fetch_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = 3,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_data,
  output logic          f_stall
`ifdef IM_ARB_FAULT_EN
  ,
  output logic          f_err,
  output logic          d_err
`endif
);
  typedef enum logic {ARB_F, ARB_D} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic f_rv, d_rv;
  logic [31:0] word;
  assign mem_addr = d_gnt ? d_addr : f_addr;
  assign f_stall = f_req & ~f_gnt;
  assign f_rvalid = f_rv & ~rst;
  assign d_rvalid = d_rv & ~rst;
`ifdef IM_ARB_FAULT_EN
  logic bad, f_eq, d_eq;
  assign bad = !(mem_addr[31:20] == 12'h9fc || mem_addr[31:20] == 12'h800) || mem_addr[1:0] != 2'b00;
  assign word = bad ? 32'h0 : mem_data;
  assign f_err = f_eq & ~rst;
  assign d_err = d_eq & ~rst;
  // error flags travel with the rvalid pulse of the offending grant
  always_ff @(posedge clk) begin
    f_eq <= ~rst & f_gnt & bad;
    d_eq <= ~rst & d_gnt & bad;
  end
`else
  assign word = mem_data;
`endif
  // grant selection follows the current priority state; next state and starvation count
  always_comb begin
    f_gnt = ~rst & f_req & (state == ARB_F | ~d_req);
    d_gnt = ~rst & d_req & (state == ARB_D | ~f_req);
    cnt_n = (d_gnt | ~d_req) ? '0 : (cnt == CNT_W'(STARVE_MAX)) ? cnt : cnt + 1'b1;
    state_n = (state == ARB_F)
      ? ((d_req & ~d_gnt & cnt == CNT_W'(STARVE_MAX - 1)) ? ARB_D : ARB_F)
      : ((d_gnt | ~d_req) ? ARB_F : ARB_D);
  end
  // state, counter and one-cycle registered read return per port
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_F;
      cnt <= '0;
      f_rv <= 1'b0;
      d_rv <= 1'b0;
      f_rdata <= 32'h0;
      d_rdata <= 32'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      f_rv <= f_gnt;
      d_rv <= d_gnt;
      if (f_gnt) f_rdata <= word;
      if (d_gnt) d_rdata <= word;
    end
  end
endmodule
